// File: rtl/stack_cmd_frontend.sv
// Command front end for the push/pop stack: synchronizes and debounces the
// raw switches, issues fixed-length command pulses, and guards occupancy.
module stack_cmd_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CMD_CYCLES      = 2,
  parameter int DEPTH           = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_sw,
  input  logic       pop_sw,
  input  logic [7:0] data_sw,
  output logic       push_o,
  output logic       pop_o,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       reject_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CNT_W = $clog2(CMD_CYCLES) + 1;
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_MAX = CNT_W'(CMD_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACT, GAP} state_t;

  // Bit 0 carries the push switch, bit 1 the pop switch throughout.
  logic [1:0]           sw_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           stable_q, stable_d, stable_prev_q;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           pend_q, pend_d, clr, rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_q, push_d, pop_q, pop_d, reject_q, reject_d;
  logic [7:0]       data_q, data_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign sw_raw = {pop_sw, push_sw};
  assign rise   = stable_q & ~stable_prev_q;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push_d   = push_q;
    pop_d    = pop_q;
    data_d   = data_q;
    occ_d    = occ_q;
    reject_d = 1'b0;
    clr      = 2'b00;
    case (state_q)
      IDLE: begin
        if (pend_q == 2'b11) begin
          clr      = 2'b11;
          reject_d = 1'b1;
        end else if (pend_q[0]) begin
          clr[0] = 1'b1;
          if (full_o) begin
            reject_d = 1'b1;
          end else begin
            push_d  = 1'b1;
            data_d  = data_sw;
            cnt_d   = '0;
            state_d = ACT;
          end
        end else if (pend_q[1]) begin
          clr[1] = 1'b1;
          if (empty_o) begin
            reject_d = 1'b1;
          end else begin
            pop_d   = 1'b1;
            cnt_d   = '0;
            state_d = ACT;
          end
        end
      end
      ACT: begin
        if (cnt_q == CMD_MAX) begin
          push_d  = 1'b0;
          pop_d   = 1'b0;
          occ_d   = push_q ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new edge in the same cycle as a clear must not be lost.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '0;
      pend_q        <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      push_q        <= 1'b0;
      pop_q         <= 1'b0;
      data_q        <= '0;
      occ_q         <= '0;
      reject_q      <= 1'b0;
    end else begin
      sync1_q       <= sw_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
      pend_q        <= pend_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      push_q        <= push_d;
      pop_q         <= pop_d;
      data_q        <= data_d;
      occ_q         <= occ_d;
      reject_q      <= reject_d;
    end
  end

  assign push_o   = push_q;
  assign pop_o    = pop_q;
  assign data_o   = data_q;
  assign reject_o = reject_q;
  assign busy_o   = (state_q != IDLE);
  assign full_o   = (occ_q == OCC_FULL);
  assign empty_o  = (occ_q == '0);

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// Bench for stack_cmd_frontend: directed and randomized switch presses
// compared against a transaction-level model of occupancy and outcomes.
module tb_stack_cmd_frontend;
  localparam int DEB = 4;
  localparam int CMD = 2;
  localparam int DEP = 4;
  localparam int LAT = 2 + DEB + 1 + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push_sw, pop_sw;
  logic [7:0] data_sw;
  logic       push_o, pop_o, busy_o, reject_o, full_o, empty_o;
  logic [7:0] data_o;

  stack_cmd_frontend #(.DEBOUNCE_CYCLES(DEB), .CMD_CYCLES(CMD), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .push_sw(push_sw), .pop_sw(pop_sw), .data_sw(data_sw),
    .push_o(push_o), .pop_o(pop_o), .data_o(data_o), .busy_o(busy_o),
    .reject_o(reject_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0, mismatched = 0;
  int push_rises = 0, push_hi = 0, push_run = 0, last_push_run = 0, push_rise_cyc = 0;
  int pop_rises = 0, pop_hi = 0, pop_run = 0, last_pop_run = 0, pop_rise_cyc = 0;
  int rej_cnt = 0, rej_run = 0, max_rej_run = 0;
  logic push_prev = 1'b0, pop_prev = 1'b0;

  always @(negedge clk) begin
    if (push_o && !push_prev) begin push_rises++; push_rise_cyc = cyc; push_run = 0; end
    if (push_o) begin push_hi++; push_run++; end
    if (!push_o && push_prev) last_push_run = push_run;
    if (pop_o && !pop_prev) begin pop_rises++; pop_rise_cyc = cyc; pop_run = 0; end
    if (pop_o) begin pop_hi++; pop_run++; end
    if (!pop_o && pop_prev) last_pop_run = pop_run;
    if (reject_o) begin rej_cnt++; rej_run++; end else rej_run = 0;
    if (rej_run > max_rej_run) max_rej_run = rej_run;
    push_prev = push_o;
    pop_prev  = pop_o;
  end

  int         m_occ = 0;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_static();
    check("data_o", int'(data_o), int'(m_data));
    check("full_o", int'(full_o), int'(m_occ == DEP));
    check("empty_o", int'(empty_o), int'(m_occ == 0));
    check("busy_o", int'(busy_o), 0);
  endtask

  task automatic do_op(input bit p, input bit q, input logic [7:0] d, input int hold);
    int s_pr, s_ph, s_qr, s_qh, s_rj, press_cyc;
    int e_push, e_pop, e_rej;
    e_push = 0; e_pop = 0; e_rej = 0;
    if (hold >= DEB) begin
      if (p && q) e_rej = 1;
      else if (p) begin
        if (m_occ == DEP) e_rej = 1;
        else begin e_push = 1; m_occ++; m_data = d; end
      end else if (q) begin
        if (m_occ == 0) e_rej = 1;
        else begin e_pop = 1; m_occ--; end
      end
    end
    @(negedge clk); #1;
    s_pr = push_rises; s_ph = push_hi; s_qr = pop_rises; s_qh = pop_hi; s_rj = rej_cnt;
    press_cyc = cyc;
    data_sw = d; push_sw = p; pop_sw = q;
    repeat (hold) @(negedge clk);
    #1; push_sw = 1'b0; pop_sw = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("push_cmds", push_rises - s_pr, e_push);
    check("push_cycles", push_hi - s_ph, e_push * CMD);
    check("pop_cmds", pop_rises - s_qr, e_pop);
    check("pop_cycles", pop_hi - s_qh, e_pop * CMD);
    check("rejects", rej_cnt - s_rj, e_rej);
    if (e_push == 1) begin
      check("push_latency", push_rise_cyc - press_cyc, LAT);
      check("push_width", last_push_run, CMD);
    end
    if (e_pop == 1) begin
      check("pop_latency", pop_rise_cyc - press_cyc, LAT);
      check("pop_width", last_pop_run, CMD);
    end
    check_static();
  endtask

  initial begin
    int kind, hold, n;
    bit seen;
    rst_n = 1'b0; push_sw = 1'b0; pop_sw = 1'b0; data_sw = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_push_o", int'(push_o), 0);
    check("rst_pop_o", int'(pop_o), 0);
    check("rst_reject_o", int'(reject_o), 0);
    check_static();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op(1, 0, 8'hA5, 6);
    do_op(1, 0, 8'h11, 2);
    do_op(1, 0, 8'h22, DEB - 1);
    do_op(0, 1, 8'h00, 6);
    do_op(0, 1, 8'h00, 6);
    for (int i = 0; i < 5; i++) do_op(1, 0, 8'h30 + 8'(i), DEB);
    do_op(0, 1, 8'h00, 6);
    check("occ_after_pop", m_occ, 3);
    do_op(1, 1, 8'h77, 6);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(2, 10);
      if (kind <= 5)      do_op(1, 0, 8'($urandom), hold);
      else if (kind <= 8) do_op(0, 1, 8'($urandom), hold);
      else                do_op(1, 1, 8'($urandom), hold);
    end

    if (m_occ == DEP) do_op(0, 1, 8'h00, 6);
    @(negedge clk); #1;
    data_sw = 8'h5A; push_sw = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (push_o) seen = 1'b1;
    end
    check("rst_test_push_seen", int'(seen), 1);
    #2; rst_n = 1'b0; push_sw = 1'b0;
    #1;
    check("async_push_drop", int'(push_o), 0);
    m_occ = 0; m_data = 8'h00;
    check_static();
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_op(1, 0, 8'h3C, 6);

    check("reject_pulse_width", max_rej_run, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
